// File: rtl/pc_unit.sv
// Program-counter unit: holds the PC, picks the next PC by redirect priority,
// and parks stalled redirects in HOLD. Optional misaligned-target trap: PC_ALIGN_CHK_EN.
module pc_unit #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0004,
  parameter int          INC       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             br_take,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             exc,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc_in,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             pend,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);
  localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VEC);
  localparam logic [WIDTH-1:0] STEP   = WIDTH'(INC);

  localparam logic [2:0] PRIO_SEQ  = 3'd0;
  localparam logic [2:0] PRIO_BR   = 3'd1;
  localparam logic [2:0] PRIO_JMP  = 3'd2;
  localparam logic [2:0] PRIO_ERET = 3'd3;
  localparam logic [2:0] PRIO_EXC  = 3'd4;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [2:0]       pend_prio;
  logic [WIDTH-1:0] pend_target;

  logic [2:0]       cur_prio;
  logic [WIDTH-1:0] cur_target;
  logic [WIDTH-1:0] rel_target;
  logic             rel_bad;
  logic             take_latch;

  assign pc_plus = pc + STEP;

  always_comb begin
    cur_prio   = PRIO_SEQ;
    cur_target = pc_plus;
    if (exc) begin
      cur_prio   = PRIO_EXC;
      cur_target = EXC_PC;
    end else if (eret) begin
      cur_prio   = PRIO_ERET;
      cur_target = epc_in;
    end else if (jmp) begin
      cur_prio   = PRIO_JMP;
      cur_target = jmp_target;
    end else if (br_take) begin
      cur_prio   = PRIO_BR;
      cur_target = br_target;
    end
  end

  // On release from HOLD the parked redirect wins ties against the live request.
  always_comb begin
    rel_target = cur_target;
    if (state == HOLD && pend_prio >= cur_prio) begin
      rel_target = pend_target;
    end
  end

`ifdef PC_ALIGN_CHK_EN
  logic rel_redirect;
  assign rel_redirect = (state == HOLD) || (cur_prio != PRIO_SEQ);
  assign rel_bad      = rel_redirect && (rel_target[1:0] != 2'b00);
`else
  assign rel_bad = 1'b0;
`endif

  // A stalled redirect is parked in RUN, or replaces an equal/lower one in HOLD.
  assign take_latch = (cur_prio != PRIO_SEQ) &&
                      ((state == RUN) || (cur_prio >= pend_prio));

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RST_PC;
      state       <= RUN;
      pend        <= 1'b0;
      pend_prio   <= PRIO_SEQ;
      pend_target <= '0;
      misalign    <= 1'b0;
    end else begin
      misalign <= 1'b0;
      if (exc) begin
        pc          <= EXC_PC;
        state       <= RUN;
        pend        <= 1'b0;
        pend_prio   <= PRIO_SEQ;
        pend_target <= '0;
      end else if (ena) begin
        if (rel_bad) begin
          pc       <= EXC_PC;
          misalign <= 1'b1;
        end else begin
          pc <= rel_target;
        end
        state       <= RUN;
        pend        <= 1'b0;
        pend_prio   <= PRIO_SEQ;
        pend_target <= '0;
      end else if (take_latch) begin
        state       <= HOLD;
        pend        <= 1'b1;
        pend_prio   <= cur_prio;
        pend_target <= cur_target;
      end
    end
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the multi-cycle/pipelined MIPS core; successor to the plain enable-gated PC register.
- Holds the PC and computes the sequential next PC.
- Arbitrates exception, eret, jump and branch redirects by priority.
- Latches redirects that arrive during a stall so none is lost. Feeds the instruction-memory address and the PC+INC link value.

Parameters:
- WIDTH, 32, PC width in bits.
- RESET_VEC, 32'h0000_0000, PC value after reset (truncated to WIDTH).
- EXC_VEC, 32'h0000_0004, exception entry address.
- INC, 4, sequential increment.

Ports:
- clk  in  1  core clock; all state updates on the falling edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  advance enable; 0 = stall.
- br_take  in  1  branch taken.
- br_target  in  WIDTH  branch target.
- jmp  in  1  jump (j/jal/jr/jalr).
- jmp_target  in  WIDTH  jump target.
- exc  in  1  exception request.
- eret  in  1  return from exception.
- epc_in  in  WIDTH  eret return address.
- pc  out  WIDTH  current PC.
- pc_plus  out  WIDTH  pc + INC, combinational.
- pend  out  1  a redirect is latched and waiting (state HOLD).
- misalign  out  1  misaligned-target flag; only meaningful with PC_ALIGN_CHK_EN.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-high, port rst. On rst: pc=RESET_VEC, pend=0, misalign=0, pend_target=0, pend_prio=0, state=RUN.
- Redirect priority (highest first): exc(4) > eret(3) > jmp(2) > br_take(1) > sequential(0).
- Selected target: EXC_VEC, epc_in, jmp_target, br_target, or pc_plus.
- pc_plus = (pc + INC) mod 2^WIDTH; wraps silently at all-ones.
- FSM has two states: RUN and HOLD.
- RUN, ena=1: pc <= selected target on the falling edge; no extra latency.
- RUN, ena=0, redirect of prio 1..3: pc holds; pend_target/pend_prio latch the redirect; go to HOLD.
- RUN, ena=0, no redirect: pc holds; stay in RUN.
- HOLD, ena=0, new redirect with prio >= pend_prio: it replaces the latched one. A lower-priority redirect is ignored. pc holds.
- HOLD, ena=1:
  - pc <= pend_target if pend_prio >= the priority of the current-cycle request; otherwise pc <= the current request's target.
  - Go to RUN and clear pend.
- exc overrides everything, in any state and regardless of ena: pc <= EXC_VEC next edge; pend cleared; state=RUN.
- Simultaneous exc and eret: exc wins.
- rst asserted mid-HOLD: pending redirect discarded; pc=RESET_VEC immediately (asynchronous).
- pend is a registered output and equals (state==HOLD).

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- Defined:
  - Any non-sequential target with target[1:0]!=0 is treated as a misaligned-fetch exception. This applies whether the target is used immediately or on release from HOLD.
  - pc <= EXC_VEC and misalign=1 for exactly one cycle, registered with the pc update.
  - Pending state is cleared.
- Not defined: targets are used unmodified; misalign is tied to 0.

Test Plan:
- Reset release, ena=1 for 3 falling edges, RESET_VEC=0 -> pc 0,4,8,12; pc_plus=16.
- pc=0x100, ena=1, br_take=1, br_target=0x200, jmp=1, jmp_target=0x300 -> pc=0x300 (jump beats branch).
- pc=0x100, ena=0, br_take=1 pulse to 0x200 -> pend=1 and pc stays 0x100. Two further stall cycles, then ena=1 -> pc=0x200, pend=0.
- HOLD holding a branch to 0x200, ena=0, jmp to 0x400 -> latched target replaced. On ena=1 -> pc=0x400.
- HOLD, ena=0, exc=1 -> pc=EXC_VEC (0x4) next edge; pend=0. Separately: rst mid-HOLD -> pc=0 asynchronously, pend=0.
- pc=0xFFFF_FFFC, ena=1 -> pc=0x0 (wrap). With PC_ALIGN_CHK_EN: jmp_target=0x202 -> pc=0x4, misalign high for one cycle. Without the macro -> pc=0x202, misalign=0.
